// File: rtl/keypad_hex_entry.sv
// Keypad operand entry: scans a 4x4 active-low matrix, debounces presses over whole
// scan frames and shifts each accepted hex digit into a 32-bit operand register.
`timescale 1ns/1ps
module keypad_hex_entry #(
   parameter int SCAN_DIV        = 300,
   parameter int DEBOUNCE_FRAMES = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [3:0]  key_col,
   input  logic        clr,
   output logic [3:0]  key_row,
   output logic        key_valid,
   output logic [3:0]  key_code,
   output logic [31:0] operand,
   output logic [3:0]  digit_cnt,
   output logic        overflow
);
   localparam int CNT_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int DCNT_W = $clog2(DEBOUNCE_FRAMES + 1);
   localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(SCAN_DIV - 1);
   localparam logic [DCNT_W-1:0] DCNT_DONE = DCNT_W'(DEBOUNCE_FRAMES);

   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      PRESS_DB   = 2'd1,
      HELD       = 2'd2,
      RELEASE_DB = 2'd3
   } state_t;

   // Index of the lowest-numbered column pulled low.
   function automatic logic [1:0] first_low(input logic [3:0] col);
      logic [1:0] idx;
      casez (col)
         4'b???0: idx = 2'd0;
         4'b??01: idx = 2'd1;
         4'b?011: idx = 2'd2;
         default: idx = 2'd3;
      endcase
      return idx;
   endfunction

   logic [3:0]        col_meta_r, col_sync_r;
   logic [CNT_W-1:0]  scan_cnt_r;
   logic [1:0]        row_idx_r;
   logic [3:0]        key_row_r;
   logic              acc_hit_r;
   logic [3:0]        acc_code_r;
   state_t            state_r, state_s;
   logic [DCNT_W-1:0] dcnt_r, dcnt_s;
   logic [3:0]        cand_r, cand_s;
   logic              accept_s;
   logic              key_valid_r;
   logic [3:0]        key_code_r;
   logic [31:0]       operand_r;
   logic [3:0]        digit_cnt_r;
   logic              overflow_r;
   logic              sample_s, frame_end_s, row_hit_s, frame_hit_s;
   logic [3:0]        frame_code_s;

   // Two-flop synchronizer on the asynchronous column inputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         col_meta_r <= 4'b1111;
         col_sync_r <= 4'b1111;
      end else begin
         col_meta_r <= key_col;
         col_sync_r <= col_meta_r;
      end
   end

   // Sample strobe and frame result; earlier rows of the frame take priority.
   always_comb begin
      sample_s    = (scan_cnt_r == CNT_LAST);
      frame_end_s = sample_s && (row_idx_r == 2'd3);
      row_hit_s   = (col_sync_r != 4'b1111);
      frame_hit_s = acc_hit_r | row_hit_s;
      if (acc_hit_r) begin
         frame_code_s = acc_code_r;
      end else begin
         frame_code_s = {row_idx_r, first_low(col_sync_r)};
      end
   end

   // Row scan counter, row rotation and per-frame hit accumulation.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         scan_cnt_r <= '0;
         row_idx_r  <= 2'd0;
         key_row_r  <= 4'b1110;
         acc_hit_r  <= 1'b0;
         acc_code_r <= 4'd0;
      end else if (sample_s) begin
         scan_cnt_r <= '0;
         row_idx_r  <= row_idx_r + 2'd1;
         key_row_r  <= {key_row_r[2:0], key_row_r[3]};
         if (frame_end_s) begin
            acc_hit_r  <= 1'b0;
            acc_code_r <= 4'd0;
         end else begin
            acc_hit_r  <= frame_hit_s;
            acc_code_r <= frame_code_s;
         end
      end else begin
         scan_cnt_r <= scan_cnt_r + CNT_W'(1);
      end
   end

   // Debounce FSM state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= IDLE;
         dcnt_r  <= '0;
         cand_r  <= 4'd0;
      end else begin
         state_r <= state_s;
         dcnt_r  <= dcnt_s;
         cand_r  <= cand_s;
      end
   end

   // Debounce FSM next state; decisions are taken only at frame end.
   always_comb begin
      state_s  = state_r;
      dcnt_s   = dcnt_r;
      cand_s   = cand_r;
      accept_s = 1'b0;
      if (frame_end_s) begin
         case (state_r)
            IDLE: begin
               if (frame_hit_s) begin
                  state_s = PRESS_DB;
                  cand_s  = frame_code_s;
                  dcnt_s  = DCNT_W'(1);
               end else begin
                  dcnt_s = '0;
               end
            end
            PRESS_DB: begin
               if (frame_hit_s && (frame_code_s == cand_r)) begin
                  if ((dcnt_r + DCNT_W'(1)) >= DCNT_DONE) begin
                     state_s  = HELD;
                     dcnt_s   = '0;
                     accept_s = 1'b1;
                  end else begin
                     dcnt_s = dcnt_r + DCNT_W'(1);
                  end
               end else begin
                  state_s = IDLE;
                  dcnt_s  = '0;
               end
            end
            HELD: begin
               if (!frame_hit_s) begin
                  state_s = RELEASE_DB;
                  dcnt_s  = DCNT_W'(1);
               end else begin
                  dcnt_s = '0;
               end
            end
            RELEASE_DB: begin
               if (frame_hit_s) begin
                  state_s = HELD;
                  dcnt_s  = '0;
               end else if ((dcnt_r + DCNT_W'(1)) >= DCNT_DONE) begin
                  state_s = IDLE;
                  dcnt_s  = '0;
               end else begin
                  dcnt_s = dcnt_r + DCNT_W'(1);
               end
            end
            default: begin
               state_s = IDLE;
               dcnt_s  = '0;
            end
         endcase
      end else begin
         state_s = state_r;
      end
   end

   // Registered key pulse and code of the last accepted key.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         key_valid_r <= 1'b0;
         key_code_r  <= 4'd0;
      end else begin
         key_valid_r <= accept_s;
         if (accept_s) begin
            key_code_r <= cand_r;
         end else begin
            key_code_r <= key_code_r;
         end
      end
   end

   // Operand assembly; clr takes precedence over a coincident digit.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         operand_r   <= 32'd0;
         digit_cnt_r <= 4'd0;
         overflow_r  <= 1'b0;
      end else if (clr) begin
         operand_r   <= 32'd0;
         digit_cnt_r <= 4'd0;
         overflow_r  <= 1'b0;
      end else if (key_valid_r) begin
         if (digit_cnt_r < 4'd8) begin
            operand_r   <= {operand_r[27:0], key_code_r};
            digit_cnt_r <= digit_cnt_r + 4'd1;
         end else begin
            overflow_r <= 1'b1;
         end
      end else begin
         operand_r <= operand_r;
      end
   end

   assign key_row   = key_row_r;
   assign key_valid = key_valid_r;
   assign key_code  = key_code_r;
   assign operand   = operand_r;
   assign digit_cnt = digit_cnt_r;
   assign overflow  = overflow_r;

endmodule

// File: tb/tb_keypad_hex_entry.sv
// Bench for keypad_hex_entry: a keypad matrix model driven frame by frame, checked
// against a frame-level debounce and operand model.
`timescale 1ns/1ps
module tb_keypad_hex_entry;
   localparam int SCAN_DIV = 4;
   localparam int DEBOUNCE = 2;
   localparam int FRAME    = 4 * SCAN_DIV;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [3:0]  key_col;
   logic        clr;
   logic [3:0]  key_row;
   logic        key_valid;
   logic [3:0]  key_code;
   logic [31:0] operand;
   logic [3:0]  digit_cnt;
   logic        overflow;
   logic [15:0] pressed;

   int tests = 0;
   int fails = 0;

   // Model state: accepted/held flag, qualifying frame run, operand image.
   bit          m_held;
   int          m_run;
   logic [3:0]  m_cand;
   logic [31:0] m_op;
   int          m_cnt;
   bit          m_ov;
   bit          m_pend;
   logic [3:0]  m_code;
   logic [3:0]  m_last;

   keypad_hex_entry #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE_FRAMES(DEBOUNCE)) dut (
      .clk(clk), .rst_n(rst_n), .key_col(key_col), .clr(clr), .key_row(key_row),
      .key_valid(key_valid), .key_code(key_code), .operand(operand),
      .digit_cnt(digit_cnt), .overflow(overflow)
   );

   always #5 clk = ~clk;

   // Matrix keypad: a pressed key shorts its driven row onto its column.
   always_comb begin
      key_col = 4'b1111;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            if (!key_row[r] && pressed[4*r+c]) key_col[c] = 1'b0;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      if (obs !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_held = 1'b0; m_run = 0; m_cand = 4'd0;
      m_op = 32'd0; m_cnt = 0; m_ov = 1'b0;
      m_pend = 1'b0; m_code = 4'd0; m_last = 4'd0;
   endtask

   // One frame of the key-acceptance rules; returns whether a press is accepted.
   task automatic model_frame(input logic [15:0] keys, output bit pulse, output logic [3:0] code);
      bit hit;
      hit   = (keys != 16'd0);
      code  = 4'd0;
      pulse = 1'b0;
      for (int k = 15; k >= 0; k--) if (keys[k]) code = 4'(k);
      if (!m_held) begin
         if (!hit) m_run = 0;
         else if (m_run > 0 && code != m_cand) m_run = 0;
         else begin
            if (m_run == 0) m_cand = code;
            m_run++;
            if (m_run == DEBOUNCE) begin
               m_held = 1'b1; m_run = 0; pulse = 1'b1;
            end
         end
      end else begin
         m_run = hit ? 0 : m_run + 1;
         if (m_run == DEBOUNCE) begin
            m_held = 1'b0; m_run = 0;
         end
      end
   endtask

   // Drive one scan frame with the given keys; clr coincides with any pending pulse.
   task automatic run_frame(input logic [15:0] keys, input bit do_clr);
      bit         exp_pulse;
      logic [3:0] exp_code;
      logic [3:0] exp_row;
      int         nv;
      pressed = keys;
      clr     = do_clr;
      if (do_clr) begin
         m_op = 32'd0; m_cnt = 0; m_ov = 1'b0;
      end else if (m_pend) begin
         if (m_cnt < 8) begin
            m_op = (m_op << 4) | 32'(m_code);
            m_cnt++;
         end else begin
            m_ov = 1'b1;
         end
      end
      m_pend = 1'b0;
      model_frame(keys, exp_pulse, exp_code);
      nv = 0;
      for (int i = 0; i < FRAME; i++) begin
         @(posedge clk);
         #1;
         clr = 1'b0;
         if (key_valid) nv++;
         exp_row = ~(4'b0001 << (((i + 1) / SCAN_DIV) % 4));
         check("key_row", 32'(key_row), 32'(exp_row));
         if (i == 7) begin
            check("operand", operand, m_op);
            check("digit_cnt", 32'(digit_cnt), 32'(m_cnt));
            check("overflow", 32'(overflow), 32'(m_ov));
            check("key_code_hold", 32'(key_code), 32'(m_last));
         end
      end
      check("valid_count", 32'(nv), 32'(exp_pulse));
      check("valid_at_end", 32'(key_valid), 32'(exp_pulse));
      if (exp_pulse) begin
         check("key_code", 32'(key_code), 32'(exp_code));
         m_pend = 1'b1;
         m_code = exp_code;
         m_last = exp_code;
      end
   endtask

   task automatic press_key(input int idx);
      run_frame(16'd1 << idx, 1'b0);
      run_frame(16'd1 << idx, 1'b0);
      run_frame(16'd0, 1'b0);
      run_frame(16'd0, 1'b0);
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "_row"}, 32'(key_row), 32'(4'b1110));
      check({tag, "_valid"}, 32'(key_valid), 32'd0);
      check({tag, "_code"}, 32'(key_code), 32'd0);
      check({tag, "_operand"}, operand, 32'd0);
      check({tag, "_cnt"}, 32'(digit_cnt), 32'd0);
      check({tag, "_ovf"}, 32'(overflow), 32'd0);
   endtask

   initial begin
      int          sel;
      int          nfr;
      logic [15:0] keys;
      rst_n   = 1'b0;
      clr     = 1'b0;
      pressed = 16'd0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check_reset_values("rst");
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // Idle scanning, then one long hold of key 6 and its release.
      run_frame(16'd0, 1'b0);
      run_frame(16'd0, 1'b0);
      for (int f = 0; f < 5; f++) run_frame(16'd1 << 6, 1'b0);
      for (int f = 0; f < 3; f++) run_frame(16'd0, 1'b0);
      check("op_key6", operand, 32'h0000_0006);
      check("cnt_key6", 32'(digit_cnt), 32'd1);

      // Too-short press of key 1.
      run_frame(16'd1 << 1, 1'b0);
      for (int f = 0; f < 3; f++) run_frame(16'd0, 1'b0);
      check("op_short", operand, 32'h0000_0006);

      // Fill all eight digits, then overflow with a ninth.
      run_frame(16'd0, 1'b1);
      for (int k = 1; k <= 8; k++) press_key(k);
      check("op_full", operand, 32'h1234_5678);
      check("cnt_full", 32'(digit_cnt), 32'd8);
      press_key(9);
      check("op_ovf", operand, 32'h1234_5678);
      check("ovf_set", 32'(overflow), 32'd1);
      check("code_9", 32'(key_code), 32'd9);

      // clr coincident with the pulse for key A discards the digit.
      run_frame(16'd1 << 10, 1'b0);
      run_frame(16'd1 << 10, 1'b0);
      run_frame(16'd0, 1'b1);
      run_frame(16'd0, 1'b0);
      check("op_clr", operand, 32'd0);
      check("cnt_clr", 32'(digit_cnt), 32'd0);
      check("ovf_clr", 32'(overflow), 32'd0);
      press_key(11);
      check("op_b", operand, 32'h0000_000B);

      // Two simultaneous keys: the first in scan order wins.
      run_frame((16'd1 << 3) | (16'd1 << 8), 1'b0);
      run_frame((16'd1 << 3) | (16'd1 << 8), 1'b0);
      run_frame(16'd0, 1'b0);
      run_frame(16'd0, 1'b0);
      check("op_multi", operand, 32'h0000_00B3);

      // Randomized key activity with occasional clears.
      for (int e = 0; e < 40; e++) begin
         sel = $urandom_range(0, 9);
         if (sel < 4) keys = 16'd0;
         else if (sel < 8) keys = 16'd1 << $urandom_range(0, 15);
         else keys = (16'd1 << $urandom_range(0, 15)) | (16'd1 << $urandom_range(0, 15));
         nfr = $urandom_range(1, 4);
         for (int f = 0; f < nfr; f++) run_frame(keys, ($urandom_range(0, 9) == 0));
      end
      for (int f = 0; f < 3; f++) run_frame(16'd0, 1'b0);

      // Reset asserted mid press-debounce; a held key must debounce afresh.
      run_frame(16'd1 << 5, 1'b0);
      repeat (5) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check_reset_values("midrst");
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      run_frame(16'd1 << 5, 1'b0);
      run_frame(16'd1 << 5, 1'b0);
      run_frame(16'd0, 1'b0);
      run_frame(16'd0, 1'b0);
      check("op_after_rst", operand, 32'h0000_0005);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
